// File: rtl/alu.sv
// rtl/alu.sv - WIDTH-bit execute-stage ALU (ADD/XOR/PASSB/SUB) with registered {V,C,N,Z} status; optional ALU_STICKY_OVF_EN makes V sticky
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       alu_op,
  input  logic             flag_en,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic [3:0]       flags_q
);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_XOR   = 2'b01;
  localparam logic [1:0] OP_PASSB = 2'b10;
  localparam logic [1:0] OP_SUB   = 2'b11;

  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;
  logic           sign_a;
  logic           sign_b;
  logic           v_next;

  assign sign_a = a[WIDTH-1];
  assign sign_b = b[WIDTH-1];

  // Extended add/subtract; the extra top bit is the carry out (add) or the borrow (sub).
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
  end

  // Operation select: result plus the carry and signed-overflow flags for that operation.
  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    unique case (alu_op)
      OP_ADD: begin
        result   = sum_ext[WIDTH-1:0];
        carry    = sum_ext[WIDTH];
        overflow = (sign_a == sign_b) && (sum_ext[WIDTH-1] != sign_a);
      end
      OP_XOR: begin
        result = a ^ b;
      end
      OP_PASSB: begin
        result = b;
      end
      OP_SUB: begin
        result   = diff_ext[WIDTH-1:0];
        carry    = ~diff_ext[WIDTH];
        overflow = (sign_a != sign_b) && (diff_ext[WIDTH-1] != sign_a);
      end
      default: begin
        result = '0;
      end
    endcase
  end

  // Zero and negative always come from the final result, whatever the operation.
  always_comb begin
    zero     = (result == '0);
    negative = result[WIDTH-1];
  end

`ifdef ALU_STICKY_OVF_EN
  // V accumulates across captures so a run of operations can be checked for any overflow.
  always_comb begin
    v_next = flags_q[3] | overflow;
  end
`else
  // V is a plain snapshot of the live overflow flag.
  always_comb begin
    v_next = overflow;
  end
`endif

  // Status register: clear beats capture; otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (flag_clr) begin
      flags_q <= 4'b0000;
    end else if (flag_en) begin
      flags_q <= {v_next, carry, negative, zero};
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - table-driven self-checking bench for alu, plus status-register sequences
module tb_alu;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       alu_op;
  logic             flag_en;
  logic             flag_clr;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             negative;
  logic             overflow;
  logic [3:0]       flags_q;

  int n_checks;
  int n_fail;

  alu #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .alu_op   (alu_op),
    .flag_en  (flag_en),
    .flag_clr (flag_clr),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .negative (negative),
    .overflow (overflow),
    .flags_q  (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  vcnz;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //            name            op     a         b         result    {V,C,N,Z}
    vecs[0]  = '{"add_1_1",      2'b00, 16'h0001, 16'h0001, 16'h0002, 4'b0000};
    vecs[1]  = '{"add_1234",     2'b00, 16'h1234, 16'h4321, 16'h5555, 4'b0000};
    vecs[2]  = '{"add_wrap",     2'b00, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101};
    vecs[3]  = '{"add_povf",     2'b00, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010};
    vecs[4]  = '{"add_novf",     2'b00, 16'h8000, 16'h8000, 16'h0000, 4'b1101};
    vecs[5]  = '{"xor_5_3",      2'b01, 16'h0005, 16'h0003, 16'h0006, 4'b0000};
    vecs[6]  = '{"xor_ffff",     2'b01, 16'hFFFF, 16'h0000, 16'hFFFF, 4'b0010};
    vecs[7]  = '{"xor_self",     2'b01, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0001};
    vecs[8]  = '{"passb_00ff",   2'b10, 16'h00FF, 16'h0001, 16'h0001, 4'b0000};
    vecs[9]  = '{"passb_abcd",   2'b10, 16'hABCD, 16'h0010, 16'h0010, 4'b0000};
    vecs[10] = '{"passb_neg",    2'b10, 16'h1234, 16'h8000, 16'h8000, 4'b0010};
    vecs[11] = '{"sub_a_3",      2'b11, 16'h000A, 16'h0003, 16'h0007, 4'b0100};
    vecs[12] = '{"sub_eq",       2'b11, 16'h0008, 16'h0008, 16'h0000, 4'b0101};
    vecs[13] = '{"sub_borrow",   2'b11, 16'h0000, 16'h0001, 16'hFFFF, 4'b0010};
    vecs[14] = '{"sub_novf",     2'b11, 16'h8000, 16'h0001, 16'h7FFF, 4'b1100};
    vecs[15] = '{"sub_povf",     2'b11, 16'h7FFF, 16'hFFFF, 16'h8000, 4'b1010};

    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    alu_op   = 2'b00;
    flag_en  = 1'b0;
    flag_clr = 1'b0;
    #12;
    chk("reset_flags", {28'd0, flags_q}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("post_reset_flags", {28'd0, flags_q}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      alu_op = vecs[i].op;
      a      = vecs[i].a;
      b      = vecs[i].b;
      #1;
      chk({vecs[i].name, "_res"}, {16'd0, result}, {16'd0, vecs[i].res});
      chk({vecs[i].name, "_vcnz"}, {28'd0, overflow, carry, negative, zero}, {28'd0, vecs[i].vcnz});
    end

    // Capture an overflowing add.
    alu_op = 2'b00; a = 16'h7FFF; b = 16'h0001; flag_en = 1'b1;
    tick();
    flag_en = 1'b0;
    chk("cap_ovf", {28'd0, flags_q}, 32'hA);

    // Hold with flag_en low while inputs change.
    a = 16'h0000; b = 16'h0000;
    tick();
    chk("hold", {28'd0, flags_q}, 32'hA);

    // Clear wins over capture.
    a = 16'hFFFF; b = 16'h0001; flag_en = 1'b1; flag_clr = 1'b1;
    tick();
    flag_en = 1'b0; flag_clr = 1'b0;
    chk("clr_wins", {28'd0, flags_q}, 32'h0);

    // Capture V=1, then capture a clean add; V sticks only with the macro on.
    a = 16'h7FFF; b = 16'h0001; flag_en = 1'b1;
    tick();
    chk("cap_ovf2", {28'd0, flags_q}, 32'hA);
    a = 16'h0001; b = 16'h0001;
    tick();
    flag_en = 1'b0;
`ifdef ALU_STICKY_OVF_EN
    chk("sticky_v", {28'd0, flags_q}, 32'h8);
`else
    chk("nonsticky_v", {28'd0, flags_q}, 32'h0);
`endif
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("clr_after", {28'd0, flags_q}, 32'h0);

    // Async reset mid-cycle clears flags without a clock; comb path keeps tracking.
    a = 16'h7FFF; b = 16'h0001; flag_en = 1'b1;
    tick();
    flag_en = 1'b0;
    chk("cap_pre_rst", {28'd0, flags_q}, 32'hA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {28'd0, flags_q}, 32'h0);
    alu_op = 2'b11; a = 16'h000A; b = 16'h0003;
    #1;
    chk("comb_in_rst", {15'd0, carry, result}, {15'd0, 1'b1, 16'h0007});
    rst_n = 1'b1;
    tick();
    chk("after_rst", {28'd0, flags_q}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
